// File: rtl/rx_fsm_if.sv
// Flit delivery and RX-buffer write bus for the receive endpoint.
// master: the rx_fsm engine (sinks flits, drives bus writes and credits).
// slave : the switch port and memory side that face the engine.
interface rx_fsm_if #(
    parameter int ID_W = 2
);
    logic            flit_vld;
    logic [ID_W-1:0] flit_id;
    logic [4:0]      flit_req;
    logic [31:0]     flit_data;
    logic            credit_return;
    logic            mem_wen;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_strobe;
    logic            mem_stall;

    modport master (
        input  flit_vld, flit_id, flit_req, flit_data, mem_stall,
        output credit_return, mem_wen, mem_addr, mem_wdata, mem_strobe
    );

    modport slave (
        output flit_vld, flit_id, flit_req, flit_data, mem_stall,
        input  credit_return, mem_wen, mem_addr, mem_wdata, mem_strobe
    );
endinterface

// File: rtl/rx_fsm.sv
// Receive-side endpoint engine.
// Flits from switch port 0 land in a DEPTH-entry FIFO (one credit per entry).
// The engine decodes each packet header, then streams the packet into its
// per-message RX buffer slot, and flags the slot valid when complete.
// Optional build macro: RX_FSM_ID_CHECK_EN -- flags err[2] when a non-header
// flit of a packet carries an id different from its header.
//
// Header encoding: bits [7:0] of the header payload give the flit count of
// the packet (header included); a value of 0 is treated as a header-only
// packet.

package chiplet_types_pkg;
    localparam int PKT_LENGTH_WIDTH = 8;

    function automatic logic [PKT_LENGTH_WIDTH-1:0] expected_num_flits(
        input logic [7:0] len_field
    );
        expected_num_flits = (len_field == 8'd0) ? 8'd1 : len_field;
    endfunction
endpackage

// state | meaning
// IDLE  | waiting for a header at the FIFO head; decodes it without popping
// WRITE | streaming packet words into the slot, one per accepted bus write
// DROP  | discarding a packet (slot still valid, or too long for the slot)
module rx_fsm
    import chiplet_types_pkg::*;
#(
    parameter int          NUM_MSGS     = 4,
    parameter logic [31:0] RX_BASE_ADDR = 32'h2000,
    parameter int          SLOT_WORDS   = 128,
    parameter int          DEPTH        = 8,
    localparam int         PKT_ID_WIDTH = $clog2(NUM_MSGS)
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    rx_fsm_if.master                             bus,
    output logic [NUM_MSGS-1:0]                  pkt_valid_o,
    output logic [NUM_MSGS*5-1:0]                pkt_src_o,
    output logic [NUM_MSGS*PKT_LENGTH_WIDTH-1:0] pkt_len_o,
    input  logic [NUM_MSGS-1:0]                  pkt_ack_i,
    output logic [2:0]                           err_o,
    input  logic                                 err_clr_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // FIFO
    logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [31:0]             fifo_data_q [DEPTH];
    logic [PKT_ID_WIDTH-1:0] fifo_id_q   [DEPTH];
    logic [4:0]              fifo_req_q  [DEPTH];
    logic                    fifo_empty, fifo_full;
    logic                    push, pop, overflow;
    logic [31:0]             head_data;
    logic [PKT_ID_WIDTH-1:0] head_id;
    logic [4:0]              head_req;

    // packet context
    logic [PKT_ID_WIDTH-1:0]     cur_id_q, cur_id_d;
    logic [4:0]                  cur_req_q, cur_req_d;
    logic [PKT_LENGTH_WIDTH-1:0] len_q, len_d;
    logic [PKT_LENGTH_WIDTH-1:0] word_q, word_d;
    logic [PKT_LENGTH_WIDTH-1:0] hdr_len;
    logic                        last_word;
    logic                        done;
    logic                        drop_err;
    logic                        id_err;

    // bus side
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] slot_base;

    // status
    logic [NUM_MSGS-1:0]                        pkt_valid_q, pkt_valid_d;
    logic [NUM_MSGS-1:0]                        set_vec;
    logic [NUM_MSGS-1:0][4:0]                   pkt_src_q;
    logic [NUM_MSGS-1:0][PKT_LENGTH_WIDTH-1:0]  pkt_len_q;
    logic [2:0]                                 err_q, err_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign head_data  = fifo_data_q[rd_ptr_q];
    assign head_id    = fifo_id_q[rd_ptr_q];
    assign head_req   = fifo_req_q[rd_ptr_q];

    // A full FIFO still accepts a flit when an entry leaves in the same cycle.
    assign push     = bus.flit_vld && (!fifo_full || pop);
    assign overflow = bus.flit_vld && fifo_full && !pop;

    assign hdr_len   = expected_num_flits(head_data[7:0]);
    assign last_word = (word_q == len_q - 1'b1);
    assign slot_base = RX_BASE_ADDR + 32'(cur_id_q) * 32'(SLOT_WORDS * 4);

    // FIFO pointers and occupancy; reset flushes without returning credits
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful below count_q
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= bus.flit_data;
            fifo_id_q[wr_ptr_q]   <= bus.flit_id;
            fifo_req_q[wr_ptr_q]  <= bus.flit_req;
        end
    end

    // State and packet-context registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            cur_id_q  <= '0;
            cur_req_q <= '0;
            len_q     <= '0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            cur_id_q  <= cur_id_d;
            cur_req_q <= cur_req_d;
            len_q     <= len_d;
            word_q    <= word_d;
        end
    end

    // Next-state, pop and bus-request decode
    always_comb begin
        state_d   = state_q;
        cur_id_d  = cur_id_q;
        cur_req_d = cur_req_q;
        len_d     = len_q;
        word_d    = word_q;
        pop       = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        done      = 1'b0;
        drop_err  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    cur_id_d  = head_id;
                    cur_req_d = head_req;
                    len_d     = hdr_len;
                    word_d    = '0;
                    if (pkt_valid_q[head_id] || (int'(hdr_len) > SLOT_WORDS)) begin
                        state_d  = DROP;
                        drop_err = 1'b1;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                mem_wen  = !fifo_empty;
                mem_addr = slot_base + 32'({word_q, 2'b00});
                if (mem_wen && !bus.mem_stall) begin
                    pop    = 1'b1;
                    word_d = word_q + 1'b1;
                    if (last_word) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end
                end
            end

            DROP: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    word_d = word_q + 1'b1;
                    if (last_word) state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

`ifdef RX_FSM_ID_CHECK_EN
    // Word 0 is the header that defined cur_id; every later entry must match it.
    assign id_err = pop && (word_q != '0) && (head_id != cur_id_q);
`else
    assign id_err = 1'b0;
`endif

    assign set_vec = done ? (NUM_MSGS'(1) << cur_id_q) : '0;

    // Status next-state: a new set beats an ack, a new error beats a clear
    always_comb begin
        pkt_valid_d = (pkt_valid_q & ~pkt_ack_i) | set_vec;
        err_d       = (err_clr_i ? 3'b000 : err_q) | {id_err, drop_err, overflow};
    end

    // Per-slot status and sticky error registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pkt_valid_q <= '0;
            pkt_src_q   <= '0;
            pkt_len_q   <= '0;
            err_q       <= '0;
        end else begin
            pkt_valid_q <= pkt_valid_d;
            err_q       <= err_d;
            if (done) begin
                pkt_src_q[cur_id_q] <= cur_req_q;
                pkt_len_q[cur_id_q] <= len_q;
            end
        end
    end

    assign bus.mem_wen       = mem_wen;
    assign bus.mem_addr      = mem_addr;
    assign bus.mem_wdata     = mem_wen ? head_data : 32'h0;
    assign bus.mem_strobe    = mem_wen ? 4'hF : 4'h0;
    assign bus.credit_return = pop;

    assign pkt_valid_o = pkt_valid_q;
    assign pkt_src_o   = pkt_src_q;
    assign pkt_len_o   = pkt_len_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_rx_fsm.sv
module tb_rx_fsm;
    import chiplet_types_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [3:0]  pkt_valid;
    logic [19:0] pkt_src;
    logic [31:0] pkt_len;
    logic [3:0]  pkt_ack;
    logic [2:0]  err;
    logic        err_clr;

    int checks = 0;
    int errors = 0;
    int cred_cnt = 0;
    int tbl_cred = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    rx_fsm_if #(.ID_W(2)) bus ();

    rx_fsm #(
        .NUM_MSGS    (4),
        .RX_BASE_ADDR(32'h2000),
        .SLOT_WORDS  (128),
        .DEPTH       (8)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .bus        (bus),
        .pkt_valid_o(pkt_valid),
        .pkt_src_o  (pkt_src),
        .pkt_len_o  (pkt_len),
        .pkt_ack_i  (pkt_ack),
        .err_o      (err),
        .err_clr_i  (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [1:0]  id;
        logic [4:0]  req;
        logic [31:0] data;
        logic        stall;
        logic [3:0]  ack;
        logic        exp_wen;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_cred;
        logic [3:0]  exp_valid;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_wr(input string name, input int idx, input logic [31:0] exp_addr,
                          input logic [31:0] exp_data);
        checks++;
        if (wr_addr_q.size() <= idx) begin
            errors++;
            $display("FAIL %s write %0d missing, only %0d writes", name, idx, wr_addr_q.size());
        end else if (wr_addr_q[idx] !== exp_addr || wr_data_q[idx] !== exp_data) begin
            errors++;
            $display("FAIL %s actual=%h/%h required=%h/%h", name, wr_addr_q[idx],
                     wr_data_q[idx], exp_addr, exp_data);
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        cred_cnt = 0;
    endtask

    task automatic step();
        @(negedge clk);
        if (bus.mem_wen && !bus.mem_stall) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
        end
        if (bus.credit_return) cred_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [4:0] req, input logic [31:0] data);
        bus.flit_vld  = 1'b1;
        bus.flit_id   = id;
        bus.flit_req  = req;
        bus.flit_data = data;
        step();
        bus.flit_vld  = 1'b0;
    endtask

    initial begin
        n_rst         = 1'b0;
        bus.flit_vld  = 1'b0;
        bus.flit_id   = '0;
        bus.flit_req  = '0;
        bus.flit_data = '0;
        bus.mem_stall = 1'b0;
        pkt_ack       = '0;
        err_clr       = 1'b0;

        // vld id req data stall ack | wen addr wdata cred valid
        vecs[0]  = '{1'b1, 2'd1, 5'd5, 32'h3,  1'b0, 4'h0, 1'b0, 32'h0,    32'h0,  1'b0, 4'h0};
        vecs[1]  = '{1'b1, 2'd1, 5'd5, 32'hA1, 1'b0, 4'h0, 1'b0, 32'h0,    32'h0,  1'b0, 4'h0};
        vecs[2]  = '{1'b1, 2'd1, 5'd5, 32'hA2, 1'b0, 4'h0, 1'b1, 32'h2200, 32'h3,  1'b1, 4'h0};
        vecs[3]  = '{1'b0, 2'd0, 5'd0, 32'h0,  1'b0, 4'h0, 1'b1, 32'h2204, 32'hA1, 1'b1, 4'h0};
        vecs[4]  = '{1'b0, 2'd0, 5'd0, 32'h0,  1'b0, 4'h0, 1'b1, 32'h2208, 32'hA2, 1'b1, 4'h0};
        vecs[5]  = '{1'b0, 2'd0, 5'd0, 32'h0,  1'b0, 4'h0, 1'b0, 32'h0,    32'h0,  1'b0, 4'h2};
        vecs[6]  = '{1'b0, 2'd0, 5'd0, 32'h0,  1'b0, 4'h2, 1'b0, 32'h0,    32'h0,  1'b0, 4'h2};
        vecs[7]  = '{1'b0, 2'd0, 5'd0, 32'h0,  1'b0, 4'h0, 1'b0, 32'h0,    32'h0,  1'b0, 4'h0};
        vecs[8]  = '{1'b1, 2'd1, 5'd5, 32'h3,  1'b0, 4'h0, 1'b0, 32'h0,    32'h0,  1'b0, 4'h0};
        vecs[9]  = '{1'b1, 2'd1, 5'd5, 32'hA1, 1'b0, 4'h0, 1'b0, 32'h0,    32'h0,  1'b0, 4'h0};
        vecs[10] = '{1'b1, 2'd1, 5'd5, 32'hA2, 1'b0, 4'h0, 1'b1, 32'h2200, 32'h3,  1'b1, 4'h0};
        vecs[11] = '{1'b0, 2'd0, 5'd0, 32'h0,  1'b1, 4'h0, 1'b1, 32'h2204, 32'hA1, 1'b0, 4'h0};
        vecs[12] = '{1'b0, 2'd0, 5'd0, 32'h0,  1'b1, 4'h0, 1'b1, 32'h2204, 32'hA1, 1'b0, 4'h0};
        vecs[13] = '{1'b0, 2'd0, 5'd0, 32'h0,  1'b0, 4'h0, 1'b1, 32'h2204, 32'hA1, 1'b1, 4'h0};
        vecs[14] = '{1'b0, 2'd0, 5'd0, 32'h0,  1'b0, 4'h0, 1'b1, 32'h2208, 32'hA2, 1'b1, 4'h0};
        vecs[15] = '{1'b0, 2'd0, 5'd0, 32'h0,  1'b0, 4'h0, 1'b0, 32'h0,    32'h0,  1'b0, 4'h2};
        vecs[16] = '{1'b0, 2'd0, 5'd0, 32'h0,  1'b0, 4'h2, 1'b0, 32'h0,    32'h0,  1'b0, 4'h2};
        vecs[17] = '{1'b0, 2'd0, 5'd0, 32'h0,  1'b0, 4'h0, 1'b0, 32'h0,    32'h0,  1'b0, 4'h0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen",    32'(bus.mem_wen), 32'h0);
        chk("rst_addr",   bus.mem_addr, 32'h0);
        chk("rst_wdata",  bus.mem_wdata, 32'h0);
        chk("rst_strobe", 32'(bus.mem_strobe), 32'h0);
        chk("rst_credit", 32'(bus.credit_return), 32'h0);
        chk("rst_valid",  32'(pkt_valid), 32'h0);
        chk("rst_err",    32'(err), 32'h0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // 3-flit packet to id 1, unstalled then with a 2-cycle stall on word 1
        for (int i = 0; i < 18; i++) begin
            bus.flit_vld  = vecs[i].vld;
            bus.flit_id   = vecs[i].id;
            bus.flit_req  = vecs[i].req;
            bus.flit_data = vecs[i].data;
            bus.mem_stall = vecs[i].stall;
            pkt_ack       = vecs[i].ack;
            @(negedge clk);
            chk($sformatf("vec%0d_wen", i),    32'(bus.mem_wen), 32'(vecs[i].exp_wen));
            chk($sformatf("vec%0d_addr", i),   bus.mem_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_wdata", i),  bus.mem_wdata, vecs[i].exp_wdata);
            chk($sformatf("vec%0d_strobe", i), 32'(bus.mem_strobe),
                vecs[i].exp_wen ? 32'hF : 32'h0);
            chk($sformatf("vec%0d_credit", i), 32'(bus.credit_return), 32'(vecs[i].exp_cred));
            chk($sformatf("vec%0d_valid", i),  32'(pkt_valid), 32'(vecs[i].exp_valid));
            if (bus.credit_return) tbl_cred++;
            @(posedge clk);
            #1;
        end
        bus.flit_vld  = 1'b0;
        bus.mem_stall = 1'b0;
        pkt_ack       = '0;
        chk("tbl_credits", 32'(tbl_cred), 32'd6);
        chk("tbl_len1",    32'(pkt_len[15:8]), 32'd3);
        chk("tbl_src1",    32'(pkt_src[9:5]), 32'd5);

        // overflow: 9 flits against a stalled bus, then drain with ack on completion
        clear_mon();
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 9; i++)
            push(2'd2, 5'd7, (i == 0) ? 32'd8 : 32'hB000_0000 + 32'(i));
        step();
        chk("ovf_err0",  32'(err[0]), 32'h1);
        chk("ovf_no_wr", 32'(wr_addr_q.size()), 32'd0);
        bus.mem_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pkt_ack = (i == 7) ? 4'b0100 : 4'b0000;
            step();
        end
        pkt_ack = '0;
        repeat (3) step();
        chk("ovf_nwr",    32'(wr_addr_q.size()), 32'd8);
        chk_wr("ovf_first", 0, 32'h2400, 32'd8);
        chk_wr("ovf_last",  7, 32'h241C, 32'hB000_0007);
        chk("ovf_cred",   32'(cred_cnt), 32'd8);
        chk("ack_set_wins", 32'(pkt_valid[2]), 32'h1);
        chk("ovf_len2",   32'(pkt_len[23:16]), 32'd8);
        chk("ovf_src2",   32'(pkt_src[14:10]), 32'd7);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("errclr", 32'(err), 32'h0);

        // duplicate to a still-valid slot is dropped, resend after ack lands
        clear_mon();
        push(2'd2, 5'd9, 32'd3);
        push(2'd2, 5'd9, 32'hC1);
        push(2'd2, 5'd9, 32'hC2);
        repeat (4) step();
        chk("drop_no_wr", 32'(wr_addr_q.size()), 32'd0);
        chk("drop_cred",  32'(cred_cnt), 32'd3);
        chk("drop_err1",  32'(err[1]), 32'h1);
        chk("drop_len2",  32'(pkt_len[23:16]), 32'd8);
        pkt_ack = 4'b0100;
        step();
        pkt_ack = '0;
        chk("ack_clear",  32'(pkt_valid[2]), 32'h0);
        clear_mon();
        push(2'd2, 5'd9, 32'd3);
        push(2'd2, 5'd9, 32'hC1);
        push(2'd2, 5'd9, 32'hC2);
        repeat (4) step();
        chk("resend_nwr", 32'(wr_addr_q.size()), 32'd3);
        chk_wr("resend_w0", 0, 32'h2400, 32'd3);
        chk_wr("resend_w2", 2, 32'h2408, 32'hC2);
        chk("resend_valid", 32'(pkt_valid[2]), 32'h1);
        chk("resend_len2",  32'(pkt_len[23:16]), 32'd3);
        chk("resend_src2",  32'(pkt_src[14:10]), 32'd9);

        // id mismatch inside a packet
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        clear_mon();
        push(2'd0, 5'd3, 32'd2);
        push(2'd3, 5'd3, 32'hD0D0_0001);
        repeat (4) step();
        chk("idm_nwr", 32'(wr_addr_q.size()), 32'd2);
        chk_wr("idm_w0", 0, 32'h2000, 32'd2);
        chk_wr("idm_w1", 1, 32'h2004, 32'hD0D0_0001);
        chk("idm_valid0", 32'(pkt_valid[0]), 32'h1);
        chk("idm_len0",   32'(pkt_len[7:0]), 32'd2);
        chk("idm_err1",   32'(err[1]), 32'h0);
`ifdef RX_FSM_ID_CHECK_EN
        chk("idm_err2", 32'(err[2]), 32'h1);
`else
        chk("idm_err2", 32'(err[2]), 32'h0);
`endif

        // reset in the middle of a stalled packet flushes it
        clear_mon();
        bus.mem_stall = 1'b1;
        push(2'd3, 5'd4, 32'd4);
        push(2'd3, 5'd4, 32'hE1);
        step();
        n_rst = 1'b0;
        #2;
        chk("rstm_wen",    32'(bus.mem_wen), 32'h0);
        chk("rstm_credit", 32'(bus.credit_return), 32'h0);
        chk("rstm_valid",  32'(pkt_valid), 32'h0);
        chk("rstm_err",    32'(err), 32'h0);
        n_rst = 1'b1;
        bus.mem_stall = 1'b0;
        @(posedge clk);
        #1;
        clear_mon();
        push(2'd3, 5'd4, 32'd1);
        repeat (4) step();
        chk("post_rst_nwr", 32'(wr_addr_q.size()), 32'd1);
        chk_wr("post_rst_w0", 0, 32'h2600, 32'd1);
        chk("post_rst_cred",  32'(cred_cnt), 32'd1);
        chk("post_rst_valid", 32'(pkt_valid), 32'h8);
        chk("post_rst_len3",  32'(pkt_len[31:24]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
